// File: rtl/mips_cpu_alu_issue.sv
// ---------------------------------------------------------------------------
// mips_cpu_alu_issue : decodes one MIPS32 ALU instruction, drives the ALU,
// waits out its latency and returns result/zero/dest over valid/ready.
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mips_cpu_alu_issue #(
  parameter int EXEC_CYCLES = 1,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             instr_valid_i,
  output logic             instr_ready_o,
  input  logic [31:0]      instr_i,
  input  logic [31:0]      rs_data_i,
  input  logic [31:0]      rt_data_i,
  output logic [3:0]       alu_op_o,
  output logic [31:0]      alu_a_o,
  output logic [31:0]      alu_b_o,
  output logic [4:0]       alu_sa_o,
  input  logic [31:0]      alu_result_i,
  input  logic             alu_zero_i,
  output logic             res_valid_o,
  input  logic             res_ready_i,
  output logic [31:0]      res_data_o,
  output logic             res_zero_o,
  output logic [4:0]       res_dest_o,
  output logic             res_err_o,
  output logic [CNT_W-1:0] issued_cnt_o
);

  localparam int             EXW       = (EXEC_CYCLES > 1) ? $clog2(EXEC_CYCLES) : 1;
  localparam logic [EXW-1:0] EXEC_LOAD = EXW'(EXEC_CYCLES - 1);
  localparam logic [3:0]     OP_NOP    = 4'd14;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_CAPT = 2'd2,
    S_RESP = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [3:0]         alu_op_q, alu_op_d;
  logic [31:0]        alu_a_q, alu_a_d;
  logic [31:0]        alu_b_q, alu_b_d;
  logic [4:0]         alu_sa_q, alu_sa_d;
  logic [31:0]        res_data_q, res_data_d;
  logic               res_zero_q, res_zero_d;
  logic [4:0]         res_dest_q, res_dest_d;
  logic               res_err_q, res_err_d;
  logic [EXW-1:0]     exec_cnt_q, exec_cnt_d;
  logic [CNT_W-1:0]   issued_q, issued_d;

  logic               dec_ok;
  logic [3:0]         dec_op;
  logic [31:0]        dec_b;
  logic [4:0]         dec_sa;
  logic [4:0]         dec_dest;
  logic [15:0]        imm;
  logic               unused_rs_field;

  assign imm             = instr_i[15:0];
  // The rs field is consumed upstream by register-read; only its data arrives here.
  assign unused_rs_field = ^instr_i[25:21];

  always_comb begin
    dec_ok   = 1'b1;
    dec_op   = OP_NOP;
    dec_b    = rt_data_i;
    dec_sa   = instr_i[10:6];
    dec_dest = instr_i[15:11];
    if (instr_i[31:26] == 6'h00) begin
      case (instr_i[5:0])
        6'h00:   dec_op = 4'd6;
        6'h02:   dec_op = 4'd7;
        6'h03:   dec_op = 4'd8;
        6'h04:   dec_op = 4'd9;
        6'h06:   dec_op = 4'd10;
        6'h07:   dec_op = 4'd11;
        6'h21:   dec_op = 4'd2;
        6'h23:   dec_op = 4'd3;
        6'h24:   dec_op = 4'd0;
        6'h25:   dec_op = 4'd1;
        6'h26:   dec_op = 4'd5;
        6'h2A:   dec_op = 4'd4;
        6'h2B:   dec_op = 4'd13;
        default: dec_ok = 1'b0;
      endcase
    end else begin
      dec_sa   = 5'd0;
      dec_dest = instr_i[20:16];
      dec_b    = {16'd0, imm};
      case (instr_i[31:26])
        6'h09:   begin dec_op = 4'd2;  dec_b = {{16{imm[15]}}, imm}; end
        6'h0A:   begin dec_op = 4'd4;  dec_b = {{16{imm[15]}}, imm}; end
        6'h0B:   begin dec_op = 4'd13; dec_b = {{16{imm[15]}}, imm}; end
        6'h0C:   dec_op = 4'd0;
        6'h0D:   dec_op = 4'd1;
        6'h0E:   dec_op = 4'd5;
        6'h0F:   dec_op = 4'd12;
        default: dec_ok = 1'b0;
      endcase
    end
  end

  always_comb begin
    state_d    = state_q;
    alu_op_d   = alu_op_q;
    alu_a_d    = alu_a_q;
    alu_b_d    = alu_b_q;
    alu_sa_d   = alu_sa_q;
    res_data_d = res_data_q;
    res_zero_d = res_zero_q;
    res_dest_d = res_dest_q;
    res_err_d  = res_err_q;
    exec_cnt_d = exec_cnt_q;
    issued_d   = issued_q;
    case (state_q)
      S_IDLE: begin
        if (instr_valid_i) begin
          res_dest_d = dec_dest;
          if (dec_ok) begin
            alu_op_d   = dec_op;
            alu_a_d    = rs_data_i;
            alu_b_d    = dec_b;
            alu_sa_d   = dec_sa;
            res_err_d  = 1'b0;
            exec_cnt_d = EXEC_LOAD;
            issued_d   = issued_q + CNT_W'(1);
            state_d    = S_EXEC;
          end else begin
            // Rejected instructions leave the ALU inputs untouched.
            res_err_d  = 1'b1;
            res_data_d = 32'd0;
            res_zero_d = 1'b0;
            state_d    = S_RESP;
          end
        end
      end
      S_EXEC: begin
        if (exec_cnt_q == '0) begin
          state_d = S_CAPT;
        end else begin
          exec_cnt_d = exec_cnt_q - EXW'(1);
        end
      end
      S_CAPT: begin
        res_data_d = alu_result_i;
        res_zero_d = alu_zero_i;
        state_d    = S_RESP;
      end
      S_RESP: begin
        if (res_ready_i) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      alu_op_q   <= OP_NOP;
      alu_a_q    <= 32'd0;
      alu_b_q    <= 32'd0;
      alu_sa_q   <= 5'd0;
      res_data_q <= 32'd0;
      res_zero_q <= 1'b0;
      res_dest_q <= 5'd0;
      res_err_q  <= 1'b0;
      exec_cnt_q <= '0;
      issued_q   <= '0;
    end else begin
      state_q    <= state_d;
      alu_op_q   <= alu_op_d;
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
      alu_sa_q   <= alu_sa_d;
      res_data_q <= res_data_d;
      res_zero_q <= res_zero_d;
      res_dest_q <= res_dest_d;
      res_err_q  <= res_err_d;
      exec_cnt_q <= exec_cnt_d;
      issued_q   <= issued_d;
    end
  end

  assign instr_ready_o = (state_q == S_IDLE);
  assign res_valid_o   = (state_q == S_RESP);
  assign alu_op_o      = alu_op_q;
  assign alu_a_o       = alu_a_q;
  assign alu_b_o       = alu_b_q;
  assign alu_sa_o      = alu_sa_q;
  assign res_data_o    = res_data_q;
  assign res_zero_o    = res_zero_q;
  assign res_dest_o    = res_dest_q;
  assign res_err_o     = res_err_q;
  assign issued_cnt_o  = issued_q;

endmodule

`default_nettype wire

// File: tb/tb_mips_cpu_alu_issue.sv
// Testbench for mips_cpu_alu_issue with a registered ALU model and an
// instruction-semantics reference model.
`default_nettype none

module tb_mips_cpu_alu_issue;

  localparam int EXEC_CYCLES = 1;
  localparam int CNT_W       = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             instr_valid = 1'b0;
  logic             instr_ready;
  logic [31:0]      instr = '0;
  logic [31:0]      rs_data = '0;
  logic [31:0]      rt_data = '0;
  logic [3:0]       alu_op;
  logic [31:0]      alu_a, alu_b;
  logic [4:0]       alu_sa;
  logic [31:0]      alu_result;
  logic             alu_zero;
  logic             res_valid;
  logic             res_ready = 1'b0;
  logic [31:0]      res_data;
  logic             res_zero;
  logic [4:0]       res_dest;
  logic             res_err;
  logic [CNT_W-1:0] issued_cnt;

  int               n_checks = 0;
  int               n_fail   = 0;
  logic [CNT_W-1:0] exp_cnt  = '0;

  always #5 clk = ~clk;

  mips_cpu_alu_issue #(.EXEC_CYCLES(EXEC_CYCLES), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .instr_valid_i(instr_valid), .instr_ready_o(instr_ready), .instr_i(instr),
    .rs_data_i(rs_data), .rt_data_i(rt_data),
    .alu_op_o(alu_op), .alu_a_o(alu_a), .alu_b_o(alu_b), .alu_sa_o(alu_sa),
    .alu_result_i(alu_result), .alu_zero_i(alu_zero),
    .res_valid_o(res_valid), .res_ready_i(res_ready), .res_data_o(res_data),
    .res_zero_o(res_zero), .res_dest_o(res_dest), .res_err_o(res_err),
    .issued_cnt_o(issued_cnt)
  );

  // Registered ALU, no reset on its result register.
  always @(posedge clk) begin
    logic [31:0] r;
    case (alu_op)
      4'd0:  r = alu_a & alu_b;
      4'd1:  r = alu_a | alu_b;
      4'd2:  r = alu_a + alu_b;
      4'd3:  r = alu_a - alu_b;
      4'd4:  r = {31'd0, $signed(alu_a) < $signed(alu_b)};
      4'd5:  r = alu_a ^ alu_b;
      4'd6:  r = alu_b << alu_sa;
      4'd7:  r = alu_b >> alu_sa;
      4'd8:  r = $signed(alu_b) >>> alu_sa;
      4'd9:  r = alu_b << alu_a[4:0];
      4'd10: r = alu_b >> alu_a[4:0];
      4'd11: r = $signed(alu_b) >>> alu_a[4:0];
      4'd12: r = alu_b << 16;
      4'd13: r = {31'd0, alu_a < alu_b};
      default: r = 32'd0;
    endcase
    alu_result <= r;
    alu_zero   <= (r == 32'd0);
  end

  function automatic logic [31:0] rtype(input logic [4:0] rs, rt, rd, sh, input logic [5:0] fn);
    rtype = {6'd0, rs, rt, rd, sh, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] opc, input logic [4:0] rs, rt, input logic [15:0] im);
    itype = {opc, rs, rt, im};
  endfunction

  // Reference: MIPS instruction semantics, plus the op code the ALU should see.
  task automatic model(input logic [31:0] ins, rs, rt, output logic ok, output logic [3:0] op,
                       output logic [31:0] b, output logic [4:0] sa, output logic [4:0] dest,
                       output logic [31:0] res);
    logic [31:0] sx, zx;
    logic [4:0]  sh;
    sx = {{16{ins[15]}}, ins[15:0]};
    zx = {16'd0, ins[15:0]};
    sh = ins[10:6];
    ok = 1'b1; op = 4'd14; res = 32'd0;
    if (ins[31:26] == 6'd0) begin
      b = rt; sa = sh; dest = ins[15:11];
      case (ins[5:0])
        6'h00: begin op = 4'd6;  res = rt << sh; end
        6'h02: begin op = 4'd7;  res = rt >> sh; end
        6'h03: begin op = 4'd8;  res = $signed(rt) >>> sh; end
        6'h04: begin op = 4'd9;  res = rt << rs[4:0]; end
        6'h06: begin op = 4'd10; res = rt >> rs[4:0]; end
        6'h07: begin op = 4'd11; res = $signed(rt) >>> rs[4:0]; end
        6'h21: begin op = 4'd2;  res = rs + rt; end
        6'h23: begin op = 4'd3;  res = rs - rt; end
        6'h24: begin op = 4'd0;  res = rs & rt; end
        6'h25: begin op = 4'd1;  res = rs | rt; end
        6'h26: begin op = 4'd5;  res = rs ^ rt; end
        6'h2A: begin op = 4'd4;  res = ($signed(rs) < $signed(rt)) ? 32'd1 : 32'd0; end
        6'h2B: begin op = 4'd13; res = (rs < rt) ? 32'd1 : 32'd0; end
        default: ok = 1'b0;
      endcase
    end else begin
      sa = 5'd0; dest = ins[20:16]; b = zx;
      case (ins[31:26])
        6'h09: begin op = 4'd2;  b = sx; res = rs + sx; end
        6'h0A: begin op = 4'd4;  b = sx; res = ($signed(rs) < $signed(sx)) ? 32'd1 : 32'd0; end
        6'h0B: begin op = 4'd13; b = sx; res = (rs < sx) ? 32'd1 : 32'd0; end
        6'h0C: begin op = 4'd0;  res = rs & zx; end
        6'h0D: begin op = 4'd1;  res = rs | zx; end
        6'h0E: begin op = 4'd5;  res = rs ^ zx; end
        6'h0F: begin op = 4'd12; res = {ins[15:0], 16'd0}; end
        default: ok = 1'b0;
      endcase
    end
  endtask

  task automatic do_instr(input logic [31:0] ins, rs, rt, input bit early_rdy);
    logic ok; logic [3:0] eop; logic [31:0] eb, eres; logic [4:0] esa, edest;
    int lat;
    model(ins, rs, rt, ok, eop, eb, esa, edest, eres);
    @(negedge clk);
    instr_valid = 1'b1; instr = ins; rs_data = rs; rt_data = rt;
    n_checks++;
    if (instr_ready !== 1'b1) begin n_fail++; $display("FAIL ready_idle ins=%h got %b want 1", ins, instr_ready); end
    @(negedge clk);
    instr_valid = 1'b0; res_ready = early_rdy;
    if (ok) begin
      exp_cnt = exp_cnt + 1'b1;
      n_checks++;
      if ({alu_op, alu_a, alu_b, alu_sa} !== {eop, rs, eb, esa}) begin
        n_fail++;
        $display("FAIL alu_drive ins=%h got op=%0d a=%h b=%h sa=%0d want op=%0d a=%h b=%h sa=%0d",
                 ins, alu_op, alu_a, alu_b, alu_sa, eop, rs, eb, esa);
      end
    end
    lat = 1;
    while (res_valid !== 1'b1 && lat < 20) begin @(negedge clk); lat++; end
    n_checks++;
    if (lat != (ok ? EXEC_CYCLES + 2 : 1)) begin
      n_fail++; $display("FAIL latency ins=%h got %0d want %0d", ins, lat, ok ? EXEC_CYCLES + 2 : 1);
    end
    n_checks++;
    if (res_data !== (ok ? eres : 32'd0) || res_zero !== (ok ? (eres == 32'd0) : 1'b0) || res_err !== !ok) begin
      n_fail++;
      $display("FAIL result ins=%h got data=%h zero=%b err=%b want data=%h zero=%b err=%b",
               ins, res_data, res_zero, res_err, ok ? eres : 32'd0, ok ? (eres == 32'd0) : 1'b0, !ok);
    end
    if (ok) begin
      n_checks++;
      if (res_dest !== edest) begin n_fail++; $display("FAIL dest ins=%h got %0d want %0d", ins, res_dest, edest); end
    end
    n_checks++;
    if (issued_cnt !== exp_cnt) begin n_fail++; $display("FAIL issued_cnt ins=%h got %0d want %0d", ins, issued_cnt, exp_cnt); end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    n_checks++;
    if (res_valid !== 1'b0 || instr_ready !== 1'b1) begin
      n_fail++; $display("FAIL handshake ins=%h got valid=%b ready=%b want 0 1", ins, res_valid, instr_ready);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    exp_cnt = '0;
    n_checks++;
    if ({instr_ready, alu_op, alu_a, alu_b, alu_sa, res_valid, res_data, res_zero, res_dest, res_err, issued_cnt} !==
        {1'b1, 4'd14, 32'd0, 32'd0, 5'd0, 1'b0, 32'd0, 1'b0, 5'd0, 1'b0, {CNT_W{1'b0}}}) begin
      n_fail++;
      $display("FAIL reset_state got rdy=%b op=%0d a=%h b=%h sa=%0d v=%b d=%h z=%b dst=%0d e=%b cnt=%0d want 1 14 0 0 0 0 0 0 0 0 0",
               instr_ready, alu_op, alu_a, alu_b, alu_sa, res_valid, res_data, res_zero, res_dest, res_err, issued_cnt);
    end
  endtask

  task automatic test_directed;
    do_instr(rtype(5'd1, 5'd2, 5'd3, 5'd0, 6'h21), 32'd5, 32'd7, 1'b0);           // ADDU
    do_instr(rtype(5'd4, 5'd5, 5'd6, 5'd0, 6'h07), 32'd4, 32'h8000_0000, 1'b0);   // SRAV
    do_instr(itype(6'h0F, 5'd0, 5'd9, 16'h1234), 32'hDEAD_BEEF, 32'd0, 1'b0);     // LUI
    do_instr(rtype(5'd1, 5'd2, 5'd7, 5'd0, 6'h23), 32'd6, 32'd6, 1'b0);           // SUBU -> zero
    do_instr(itype(6'h0B, 5'd1, 5'd2, 16'hFFFF), 32'd1, 32'd0, 1'b0);            // SLTIU
    do_instr(itype(6'h0C, 5'd1, 5'd2, 16'hFFFF), 32'h1234_5678, 32'd0, 1'b0);     // ANDI
    do_instr(itype(6'h23, 5'd1, 5'd2, 16'h0004), 32'd1, 32'd2, 1'b0);            // LW, rejected
    do_instr(rtype(5'd1, 5'd2, 5'd3, 5'd4, 6'h03), 32'd0, 32'hF000_0001, 1'b1);   // SRA, early ready
  endtask

  task automatic test_random;
    logic [5:0] rfn [13] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h21, 6'h23, 6'h24, 6'h25, 6'h26, 6'h2A, 6'h2B};
    logic [5:0] iop [7]  = '{6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F};
    for (int i = 0; i < 40; i++) begin
      logic [31:0] ins, rs, rt;
      int k;
      k  = $urandom_range(0, 24);
      rs = $urandom;
      rt = ($urandom_range(0, 3) == 0) ? rs : $urandom;
      ins = $urandom;
      if (k < 13)      ins[31:26] = 6'd0;
      if (k < 13)      ins[5:0] = rfn[k];
      else if (k < 20) ins[31:26] = iop[k-13];
      else if (k == 20) ins[31:26] = 6'h23;
      else if (k == 21) ins[31:26] = 6'h04;
      else begin ins[31:26] = 6'd0; ins[5:0] = (k == 22) ? 6'h08 : (k == 23) ? 6'h20 : 6'h22; end
      do_instr(ins, rs, rt, 1'($urandom_range(0, 1)));
    end
  endtask

  task automatic test_backpressure;
    logic [31:0] d; logic z, e; logic [4:0] dst; int w;
    @(negedge clk);
    instr_valid = 1'b1; instr = rtype(5'd1, 5'd2, 5'd12, 5'd0, 6'h23); rs_data = 32'd9; rt_data = 32'd9;
    @(negedge clk);
    exp_cnt = exp_cnt + 1'b1;
    instr = rtype(5'd1, 5'd2, 5'd13, 5'd0, 6'h21); rs_data = 32'd1;     // must be ignored while busy
    w = 0;
    while (res_valid !== 1'b1 && w < 20) begin @(negedge clk); w++; end
    d = res_data; z = res_zero; e = res_err; dst = res_dest;
    n_checks++;
    if ({d, z, e, dst} !== {32'd0, 1'b1, 1'b0, 5'd12}) begin
      n_fail++; $display("FAIL bp_result got d=%h z=%b e=%b dst=%0d want 0 1 0 12", d, z, e, dst);
    end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      n_checks++;
      if ({res_valid, instr_ready, res_data, res_zero, res_err, res_dest, issued_cnt} !== {1'b1, 1'b0, d, z, e, dst, exp_cnt}) begin
        n_fail++;
        $display("FAIL bp_hold c=%0d got v=%b rdy=%b d=%h z=%b e=%b dst=%0d cnt=%0d want 1 0 %h %b %b %0d %0d",
                 c, res_valid, instr_ready, res_data, res_zero, res_err, res_dest, issued_cnt, d, z, e, dst, exp_cnt);
      end
    end
    instr_valid = 1'b0; res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    n_checks++;
    if (res_valid !== 1'b0 || issued_cnt !== exp_cnt) begin
      n_fail++; $display("FAIL bp_release got v=%b cnt=%0d want 0 %0d", res_valid, issued_cnt, exp_cnt);
    end
  endtask

  task automatic test_reset_abort;
    int seen;
    @(negedge clk);
    instr_valid = 1'b1; instr = rtype(5'd1, 5'd2, 5'd3, 5'd0, 6'h21); rs_data = 32'd5; rt_data = 32'd7;
    @(negedge clk);
    instr_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({res_valid, instr_ready, issued_cnt, alu_op, alu_a} !== {1'b0, 1'b1, {CNT_W{1'b0}}, 4'd14, 32'd0}) begin
      n_fail++; $display("FAIL abort_state got v=%b rdy=%b cnt=%0d op=%0d a=%h want 0 1 0 14 0",
                         res_valid, instr_ready, issued_cnt, alu_op, alu_a);
    end
    @(negedge clk);
    rst_n = 1'b1;
    exp_cnt = '0;
    seen = 0;
    repeat (5) begin @(negedge clk); if (res_valid === 1'b1) seen++; end
    n_checks++;
    if (seen != 0) begin n_fail++; $display("FAIL abort_no_valid got %0d valid cycles want 0", seen); end
  endtask

  task automatic test_wrap;
    for (int i = 0; i < (1 << CNT_W); i++) begin
      do_instr(rtype(5'd1, 5'd2, 5'd3, 5'd0, 6'h25), i, 32'd0, 1'b1);
    end
    n_checks++;
    if (issued_cnt !== '0) begin n_fail++; $display("FAIL wrap got %0d want 0", issued_cnt); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_random();
    test_reset_abort();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
